// File: rtl/a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_sched
//  Purpose  : Round-robin ADC conversion scheduler driving a shared SPI master.
//             Optional conversion timeout enabled by macro A2D_TMO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module a2d_sched #(
  parameter int SAMP_PER = 4096,
  parameter int TMO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        err
);

  typedef enum logic [2:0] {
    WAIT_PER = 3'd0,
    CMD      = 3'd1,
    WAIT1    = 3'd2,
    GAP      = 3'd3,
    READ     = 3'd4,
    WAIT2    = 3'd5,
    STORE    = 3'd6
  } state_t;

  localparam logic [15:0] c_per_last  = 16'(SAMP_PER - 1);
  localparam logic [1:0]  c_last_slot = 2'd3;

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_cnt;
  logic [1:0]  r_slot;
  logic [2:0]  w_ch;
  logic        w_waiting;
  logic        w_tmo;
  logic        w_unused_rd;

  assign w_unused_rd = ^rd_data[15:12];
  assign w_waiting   = (r_state == WAIT1) || (r_state == WAIT2);

  // Slot order lft_ld, rght_ld, steer_pot, batt maps to ADC channels 0,4,5,6
  always_comb begin
    w_ch = 3'd0;
    case (r_slot)
      2'd0:    w_ch = 3'd0;
      2'd1:    w_ch = 3'd4;
      2'd2:    w_ch = 3'd5;
      default: w_ch = 3'd6;
    endcase
  end

  assign cmd = {2'b00, w_ch, 11'h000};

  always_comb begin
    w_nxt = r_state;
    wrt   = 1'b0;
    vld   = 1'b0;
    case (r_state)
      WAIT_PER: if (en && (r_cnt == c_per_last)) w_nxt = CMD;
      CMD: begin
        wrt   = 1'b1;
        w_nxt = WAIT1;
      end
      WAIT1: begin
        if (done)       w_nxt = GAP;
        else if (w_tmo) w_nxt = WAIT_PER;
      end
      GAP:  w_nxt = READ;
      READ: begin
        wrt   = 1'b1;
        w_nxt = WAIT2;
      end
      WAIT2: begin
        if (done)       w_nxt = STORE;
        else if (w_tmo) w_nxt = WAIT_PER;
      end
      STORE: begin
        if (r_slot == c_last_slot) begin
          vld   = 1'b1;
          w_nxt = WAIT_PER;
        end else begin
          w_nxt = CMD;
        end
      end
      default: w_nxt = WAIT_PER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_PER;
      r_cnt     <= 16'd0;
      r_slot    <= 2'd0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      r_state <= w_nxt;
      // Period counter only runs in WAIT_PER with en high; it is 0 elsewhere
      if ((r_state == WAIT_PER) && en && (r_cnt != c_per_last))
        r_cnt <= r_cnt + 16'd1;
      else
        r_cnt <= 16'd0;
      if (w_tmo)
        r_slot <= 2'd0;
      else if (r_state == STORE)
        r_slot <= r_slot + 2'd1;
      // The first transaction of each pair returns the previous conversion
      if ((r_state == WAIT2) && done) begin
        case (r_slot)
          2'd0:    lft_ld    <= rd_data[11:0];
          2'd1:    rght_ld   <= rd_data[11:0];
          2'd2:    steer_pot <= rd_data[11:0];
          default: batt      <= rd_data[11:0];
        endcase
      end
    end
  end

`ifdef A2D_TMO_EN
  localparam int c_tmo_w = $clog2(TMO_CYC + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYC - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

  logic [c_tmo_w-1:0] r_tmo;
  logic               r_err;

  // Loading 1 on wrt counts the wrt cycle itself, so err rises TMO_CYC cycles after wrt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (wrt)
        r_tmo <= c_tmo_one;
      else if (w_waiting)
        r_tmo <= r_tmo + c_tmo_one;
      if (w_tmo)
        r_err <= 1'b1;
      else if (vld)
        r_err <= 1'b0;
    end
  end

  assign w_tmo = w_waiting && !done && (r_tmo == c_tmo_last);
  assign err   = r_err;
`else
  localparam int c_unused_tmo = TMO_CYC;
  logic w_unused_wait;
  assign w_unused_wait = w_waiting;
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a2d_sched
//  Purpose  : Self-checking bench for a2d_sched with a queue-based SPI/ADC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_sched;
  localparam int SAMP_PER = 4096;
  localparam int TMO_CYC  = 1024;

  typedef logic [3:0][11:0] quad_t;   // index 0 lft_ld .. 3 batt
  typedef struct packed {
    logic [7:0] lat;
    quad_t      rsp;
    quad_t      exp;
  } vec_t;
  typedef struct {
    int          c;
    logic [15:0] cmd;
  } wrt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wrt, done, vld, err;
  logic [15:0] cmd, rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  a2d_sched #(.SAMP_PER(SAMP_PER), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .vld(vld), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- SPI master / ADC model ----------------
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;
  logic        inj_done = 1'b0;
  logic [15:0] inj_rd = 16'h0ABC;
  assign done    = spi_done | inj_done;
  assign rd_data = inj_done ? inj_rd : spi_rd;

  logic [15:0] rsp_q[$];
  wrt_t        wlog[$];
  int          spi_lat = 40;
  int          drop_idx = -1;
  bit          pend = 1'b0;
  int          due = 0;
  logic [15:0] pend_rd = 16'h0000;
  int          n_overlap = 0;
  int          n_vld = 0;
  int          vld_cyc = 0;

  // Each wrt pops one reply word; done returns it spi_lat cycles later
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (pend && cyc == due) begin
      spi_done = 1'b1;
      spi_rd   = pend_rd;
      pend     = 1'b0;
    end
    if (rst_n && wrt) begin
      if (pend) n_overlap++;
      wlog.push_back('{cyc, cmd});
      pend_rd = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hDEAD;
      pend    = ((wlog.size() - 1) != drop_idx);
      due     = cyc + spi_lat;
    end
    if (rst_n && vld) begin
      n_vld++;
      vld_cyc = cyc;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic quad_t pk(input logic [11:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic quad_t regs_now();
    return {batt, steer_pot, rght_ld, lft_ld};
  endfunction

  function automatic logic [15:0] exp_cmd(input int slot);
    logic [15:0] t [4];
    t = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    return t[slot];
  endfunction

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_wrt(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wlog.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_vld(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (vld) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_round(input quad_t rsp);
    for (int k = 0; k < 4; k++) begin
      rsp_q.push_back({4'h7, ~rsp[k]});       // stale result, must be discarded
      rsp_q.push_back({4'hA, rsp[k]});
    end
  endtask

  // One full round: first wrt time, cmd sequence, latency, single vld, registers
  task automatic round(input string nm, input int lat, input quad_t rsp, input quad_t exp,
                       input int exp_start, input bit inj_gap, input bit drop_en);
    bit    ok;
    int    v0;
    int    vat;
    quad_t q;
    spi_lat = lat;
    push_round(rsp);
    v0 = n_vld;
    wait_wrt(1, 2 * SAMP_PER + 100, ok);
    check({nm, "_wrt_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({nm, "_start"}, 32'(wlog[0].c), 32'(exp_start));
      if (drop_en) en = 1'b0;
      if (inj_gap) begin
        at_cyc(wlog[0].c + lat + 1);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
      end
      wait_vld(8 * lat + 100, ok);
      check({nm, "_vld_seen"}, 32'(ok), 32'd1);
      vat = cyc;
      repeat (3) @(negedge clk);
      check({nm, "_vld_cnt"}, 32'(n_vld - v0), 32'd1);
      check({nm, "_nwrt"}, 32'(wlog.size()), 32'd8);
      for (int k = 0; k < wlog.size() && k < 8; k++)
        check($sformatf("%s_cmd%0d", nm, k), 32'(wlog[k].cmd), 32'(exp_cmd(k / 2)));
      check({nm, "_latency"}, 32'(vat - wlog[0].c), 32'(8 * lat + 15));
      q = regs_now();
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_reg%0d", nm, k), 32'(q[k]), 32'(exp[k]));
      check({nm, "_err"}, 32'(err), 32'd0);
    end
    wlog.delete();
  endtask

  // ---------------- test sequence ----------------
  vec_t vec [3];

  initial begin
    int    rel;
    int    t_due;
    int    e;
    bit    ok;
    quad_t rr;
    quad_t q;

    vec[0] = '{8'd40, pk(12'h400, 12'h400, 12'h800, 12'hFFF), pk(12'h400, 12'h400, 12'h800, 12'hFFF)};
    vec[1] = '{8'd1,  pk(12'h000, 12'hFFF, 12'h001, 12'h7FE), pk(12'h000, 12'hFFF, 12'h001, 12'h7FE)};
    vec[2] = '{8'd13, pk(12'hA5A, 12'h5A5, 12'h123, 12'hFED), pk(12'hA5A, 12'h5A5, 12'h123, 12'hFED)};

    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wrt", 32'(wrt), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h0000);
    check("rst_regs", 32'(regs_now() != '0), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    rel = cyc;
    rst_n = 1'b1;
    round("tab0", int'(vec[0].lat), vec[0].rsp, vec[0].exp, rel + SAMP_PER, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++)
      round($sformatf("tab%0d", i), int'(vec[i].lat), vec[i].rsp, vec[i].exp,
            vld_cyc + SAMP_PER + 1, 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) rr[k] = 12'($urandom);
      round($sformatf("rnd%0d", i), int'($urandom_range(1, 60)), rr, rr,
            vld_cyc + SAMP_PER + 1, 1'b0, 1'b0);
    end

    // Stray done in WAIT_PER, then in GAP of the next round
    q = regs_now();
    at_cyc(vld_cyc + 100);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    check("inj_wp_regs", 32'(regs_now() == q), 32'd1);
    check("inj_wp_nowrt", 32'(wlog.size()), 32'd0);
    rr = pk(12'h111, 12'h222, 12'h333, 12'h444);
    round("inj_gap", 20, rr, rr, vld_cyc + SAMP_PER + 1, 1'b1, 1'b0);

    // Reset during WAIT2 of steer_pot
    spi_lat = 40;
    push_round(pk(12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0));
    wait_wrt(6, 2 * SAMP_PER + 400, ok);
    check("rstmid_reach", 32'(ok), 32'd1);
    if (ok) begin
      t_due = wlog[5].c + 40;
      at_cyc(wlog[5].c + 5);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_wrt", 32'(wrt), 32'd0);
      check("rstmid_cmd", 32'(cmd), 32'h0000);
      check("rstmid_regs", 32'(regs_now() != '0), 32'd0);
      check("rstmid_vld_err", 32'({vld, err}), 32'd0);
      rsp_q.delete();
      repeat (3) @(negedge clk);
      wlog.delete();
      rel = cyc;
      rst_n = 1'b1;
      at_cyc(t_due + 2);
      check("rstmid_late_done", 32'(regs_now() != '0), 32'd0);
      check("rstmid_nowrt", 32'(wlog.size()), 32'd0);
      rr = pk(12'h9AB, 12'hCDE, 12'h0F1, 12'h234);
      round("rst_after", 40, rr, rr, rel + SAMP_PER, 1'b0, 1'b0);
    end

    // en dropped mid-round, then held low for 10000 cycles
    rr = pk(12'h321, 12'h654, 12'h987, 12'hCBA);
    round("en_drop", 25, rr, rr, vld_cyc + SAMP_PER + 1, 1'b0, 1'b1);
    repeat (10000) @(negedge clk);
    check("en_low_nowrt", 32'(wlog.size()), 32'd0);
    e = cyc;
    en = 1'b1;
    rr = pk(12'h00F, 12'h0F0, 12'hF00, 12'h5A5);
    round("en_rise", 10, rr, rr, e + SAMP_PER, 1'b0, 1'b0);

`ifdef A2D_TMO_EN
    // Withhold done after the rght_ld READ
    drop_idx = 3;
    spi_lat = 40;
    e = n_vld;
    push_round(pk(12'h111, 12'h111, 12'h111, 12'h111));
    wait_wrt(4, 2 * SAMP_PER + 400, ok);
    check("tmo_reach", 32'(ok), 32'd1);
    if (ok) begin
      rel = wlog[3].c;
      ok = 1'b0;
      for (int i = 0; i < 2 * TMO_CYC; i++) begin
        @(negedge clk);
        if (err) begin ok = 1'b1; break; end
      end
      check("tmo_err", 32'(ok), 32'd1);
      t_due = cyc;
      check("tmo_time", 32'(t_due - rel), 32'(TMO_CYC));
      drop_idx = -1;
      repeat (3) @(negedge clk);
      check("tmo_novld", 32'(n_vld - e), 32'd0);
      check("tmo_nwrt", 32'(wlog.size()), 32'd4);
      rsp_q.delete();
      wlog.delete();
      check("tmo_sticky", 32'(err), 32'd1);
      rr = pk(12'h777, 12'h888, 12'h999, 12'hAAA);
      round("tmo_next", 30, rr, rr, t_due + SAMP_PER, 1'b0, 1'b0);
    end
`endif

    check("no_overlap", 32'(n_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 Parameter SAMP_PER, default 4096: clock cycles spent idle between conversion rounds.
REQ-002 Parameter TMO_CYC, default 1024: maximum cycles to wait for done after a wrt pulse.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  scheduler enable; while low, no new round starts.
REQ-006 wrt  out  1  single-cycle pulse that starts one 16-bit SPI transaction on the shared SPI master.
REQ-007 cmd  out  16  SPI command word: {2'b00, ch[2:0], 11'h000}.
REQ-008 done  in  1  SPI transaction complete, from the SPI master.
REQ-009 rd_data  in  16  received SPI word; only bits [11:0] are used.
REQ-010 lft_ld, rght_ld, steer_pot, batt  out  12 each  latest conversion results.
REQ-011 vld  out  1  single-cycle pulse when a full 4-channel round has completed.
REQ-012 err  out  1  conversion timeout flag.

Function
REQ-013 States: WAIT_PER, CMD, WAIT1, GAP, READ, WAIT2, STORE.
REQ-014 The channel sequence for each round shall be fixed: lft_ld ch0, rght_ld ch4, steer_pot ch5, batt ch6; after batt it wraps to lft_ld.
REQ-015 WAIT_PER: a 16-bit counter increments every cycle while en=1 and holds at 0 while en=0; at SAMP_PER-1 it clears and the FSM moves to CMD.
REQ-016 CMD: assert wrt for exactly 1 cycle with cmd for the current channel, then go to WAIT1.
REQ-017 WAIT1: on done=1, go to GAP; rd_data is discarded, because the ADC returns the result one transaction late.
REQ-018 GAP: 1 idle cycle, then READ.
REQ-019 READ: assert wrt for 1 cycle with the same cmd value, then go to WAIT2.
REQ-020 WAIT2: on done=1, load rd_data[11:0] into the current channel's register on that same edge, then go to STORE.
REQ-021 STORE: if the channel was not the last one, advance the channel and go to CMD; if it was batt, wrap the channel, pulse vld for 1 cycle, clear err, and go to WAIT_PER.
REQ-022 Minimum round latency: wrt-to-done time plus 3 cycles per channel.
REQ-023 cmd shall hold its value from the wrt pulse until STORE completes.
REQ-024 done in any state other than WAIT1 or WAIT2 shall be ignored.
REQ-025 Deasserting en mid-round shall not abort the round; it takes effect only in WAIT_PER.
REQ-026 wrt shall never assert while the FSM is in WAIT1 or WAIT2, so at most one SPI transaction is outstanding.
REQ-027 Result registers shall update only in WAIT2 on done; a partial round leaves the remaining registers unchanged.

Reset
REQ-028 While rst_n=0: FSM in WAIT_PER, counter 0, channel index lft_ld, wrt 0, cmd 16'h0000, all result registers 12'h000, vld 0, err 0.
REQ-029 Reset asserted mid-transaction shall abort immediately; done arriving after reset release shall be ignored per REQ-024.
REQ-030 The first wrt after reset release shall occur exactly SAMP_PER cycles after release, with en held at 1.

Configuration
REQ-031 Macro A2D_TMO_EN, when defined: a timeout counter clears on each wrt, counts in WAIT1 and WAIT2, and on reaching TMO_CYC without done it sets err, aborts the round with no vld, resets the channel to lft_ld, and returns to WAIT_PER.
REQ-032 err under A2D_TMO_EN shall be sticky until the next vld pulse or reset.
REQ-033 When A2D_TMO_EN is undefined: err tied to 0, no timeout counter present, and WAIT1 and WAIT2 wait indefinitely.

Verification
REQ-034 Reset release, en=1, SAMP_PER=4096 -> first wrt at cycle 4096 with cmd=16'h0000.
REQ-035 SPI model with done 40 cycles after each wrt, returning 12'h400, 12'h400, 12'h800, 12'hFFF -> wrt sequence shows cmd 0x0000 x2, 0x2000 x2, 0x2800 x2, 0x3000 x2; registers hold lft_ld=400, rght_ld=400, steer_pot=800, batt=FFF; exactly 1 vld pulse.
REQ-036 done pulsed in WAIT_PER and in GAP -> no state change and no register update.
REQ-037 rst_n pulled low during the WAIT2 of steer_pot -> all outputs 0 immediately; after release, the round restarts at lft_ld after 4096 cycles.
REQ-038 en=0 for 10000 cycles -> no wrt; after en rises, wrt occurs 4096 cycles later.
REQ-039 With A2D_TMO_EN defined and done withheld after the rght_ld READ -> err=1 at wrt+1024, no vld, next round starts at lft_ld; a subsequent good round clears err on its vld.
